conv_loop_addr_counter: RTL and testbench
=========================================

// Module: conv_loop_addr_counter
// PURPOSE
//  Nested multi-dimensional loop counter for the convolution datapath: walks NUM_DIMS loops
//  (dim0 innermost), each with a runtime bound and address stride.
//  Emits one linear buffer address per valid/ready transfer, plus per-dim indices and wrap flags.
//  Successor to the single-dimension fixed-offset up-counter; adds runtime bounds, backpressure,
//  start/done control and per-dim strides.
// PARAMETERS
//  NUM_DIMS    3   number of nested loops (1..4)
//  CNT_WIDTH   8   width of each per-dim index and bound
//  ADDR_WIDTH  16  width of base, strides and output address
// PORTS
//  clk          in   1                    clock
//  rst_n        in   1                    asynchronous, active-low reset
//  start_i      in   1                    start pulse; config sampled on this cycle (IDLE only)
//  base_i       in   ADDR_WIDTH           start address
//  bound_i      in   NUM_DIMS*CNT_WIDTH   iterations per dim, dim d at [d*CNT_WIDTH +: CNT_WIDTH]
//  stride_i     in   NUM_DIMS*ADDR_WIDTH  address step per dim-d increment, same packing
//  out_ready_i  in   1                    consumer accepts addr_o
//  valid_o      out  1                    addr_o/idx_o/last_o valid
//  addr_o       out  ADDR_WIDTH           current linear address
//  idx_o        out  NUM_DIMS*CNT_WIDTH   current index per dim
//  last_o       out  NUM_DIMS             bit d = idx[d]==bound[d]-1 (qualified by valid_o)
//  busy_o       out  1                    state != IDLE
//  done_o       out  1                    1-cycle pulse after final transfer
// BEHAVIOUR
//  - Reset: state=IDLE; valid_o, busy_o, done_o, last_o = 0; idx_o = 0; addr_o = 0.
//  - FSM: IDLE -(start_i)-> RUN -(final transfer)-> DONE -(next cycle)-> IDLE.
//  - start_i latches base/bound/stride; cycle after: valid_o=1, idx=0, addr_o=base. start_i ignored outside IDLE.
//  - Bound of 0 is treated as 1.
//  - Transfer = valid_o & out_ready_i. Without a transfer, all outputs hold stable (no change under stall).
//  - On transfer, carry chain: dim0 increments; dim d wraps to 0 when idx[d]==bound[d]-1,
//    carrying into dim d+1. Only the lowest non-wrapping dim k increments.
//  - Address: per-dim row-base registers rb[d]; addr_o = rb[0].
//    On increment of dim k: rb[k] += stride[k], then rb[j] = new rb[k] for all j<k.
//    Arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
//  - Final transfer: all last_o bits set. Sequence: valid_o drops next cycle, state=DONE with done_o=1
//    for exactly one cycle, then IDLE. Earliest accepted next start_i is in IDLE (DONE+1).
//  - Throughput: 1 address/cycle with out_ready_i held high; total transfers = product of bounds.
//  - Reset mid-run: asynchronous return to reset values; no done_o is produced.
// CONFIGURATION
//  - `CONV_CNT_ABORT_EN defined: adds input abort_i (1 bit).
//    abort_i=1 in RUN -> next cycle IDLE, valid_o=0, no done_o; abort_i ignored in IDLE/DONE;
//    abort wins over a same-cycle transfer (the address is counted as not consumed).
//  - `CONV_CNT_ABORT_EN undefined: no abort_i port; a run only ends via final transfer or reset.
// STRUCTURE
//  - Package conv_cnt_pkg: FSM state localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2),
//    default NUM_DIMS/CNT_WIDTH/ADDR_WIDTH constants, bound-sanitise function (0 -> 1).
//  - Sub-module conv_loop_dim_stage (generated NUM_DIMS times):
//    index register, bound compare (last), carry_in/carry_out, row-base register with load/step.
//  - Top level: FSM, config latches, carry chain wiring, rb broadcast on increment.
// TESTING
//  1. base=0x100, bounds {2,3,4}, strides {0x40,0x10,1}, ready=1 -> 24 transfers: 0x100..0x103, 0x110..,
//     0x120.., 0x140..0x163; done_o pulses 1 cycle after the 24th.
//  2. Same config, out_ready_i toggled 1-0-0-1 -> outputs hold during stalls; same 24-address sequence.
//  3. bounds {1,1,0} -> exactly 1 transfer at base; last_o=3'b111; done_o follows.
//  4. base=0xFFF0, bound0=40, stride0=1 (16-bit) -> addr wraps 0xFFFF->0x0000 at transfer 16.
//  5. start_i asserted mid-RUN -> ignored; rst_n low mid-RUN -> valid_o/busy_o 0 immediately, no done_o.
//  6. With `CONV_CNT_ABORT_EN: abort_i at transfer 5 (coinciding with a transfer) -> IDLE next cycle, no done_o;
//     a new start_i is then accepted.

Source files
------------

// File: rtl/conv_cnt_pkg.sv
// Shared types and defaults for the nested convolution loop address counter.
package conv_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_DIMS   = 3;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 16;

  // A zero iteration count is run as a single iteration.
  function automatic int unsigned sanitise_bound(input int unsigned b);
    return (b == 0) ? 1 : b;
  endfunction

endpackage

// File: rtl/conv_loop_dim_stage.sv
// One loop dimension: index register, last-iteration compare, carry, and row-base address.
module conv_loop_dim_stage #(
  parameter int CNT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [CNT_WIDTH-1:0]  bound_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic                  carry_i,
  input  logic [ADDR_WIDTH-1:0] bcast_i,
  output logic [CNT_WIDTH-1:0]  idx_o,
  output logic                  last_o,
  output logic                  carry_o,
  output logic [ADDR_WIDTH-1:0] rb_o
);

  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] rb_q, rb_d;

  assign last_o  = (idx_q == bound_i - CNT_WIDTH'(1));
  assign carry_o = carry_i & last_o;
  assign idx_o   = idx_q;
  assign rb_o    = rb_q;

  // A wrapping dim restarts at the row base of whichever higher dim advanced.
  always_comb begin
    idx_d = idx_q;
    rb_d  = rb_q;
    if (load_i) begin
      idx_d = '0;
      rb_d  = base_i;
    end else if (carry_i) begin
      if (last_o) begin
        idx_d = '0;
        rb_d  = bcast_i;
      end else begin
        idx_d = idx_q + CNT_WIDTH'(1);
        rb_d  = rb_q + stride_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      rb_q  <= '0;
    end else begin
      idx_q <= idx_d;
      rb_q  <= rb_d;
    end
  end

endmodule

// File: rtl/conv_loop_addr_counter.sv
// Nested NUM_DIMS loop address generator with valid/ready output and start/done control.
// Optional abort input is enabled by defining CONV_CNT_ABORT_EN.
module conv_loop_addr_counter
  import conv_cnt_pkg::*;
#(
  parameter int NUM_DIMS   = DEF_NUM_DIMS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic [ADDR_WIDTH-1:0]          base_i,
  input  logic [NUM_DIMS*CNT_WIDTH-1:0]  bound_i,
  input  logic [NUM_DIMS*ADDR_WIDTH-1:0] stride_i,
  input  logic                           out_ready_i,
`ifdef CONV_CNT_ABORT_EN
  input  logic                           abort_i,
`endif
  output logic                           valid_o,
  output logic [ADDR_WIDTH-1:0]          addr_o,
  output logic [NUM_DIMS*CNT_WIDTH-1:0]  idx_o,
  output logic [NUM_DIMS-1:0]            last_o,
  output logic                           busy_o,
  output logic                           done_o
);

  state_t state_q, state_d;
  logic   load, xfer, abort, final_xfer;

  logic [NUM_DIMS-1:0]                 last_vec;
  logic [NUM_DIMS-1:0][ADDR_WIDTH-1:0] rb_all;
  logic [NUM_DIMS-1:0][ADDR_WIDTH-1:0] stride_all;
  logic [ADDR_WIDTH-1:0]               bcast;

`ifdef CONV_CNT_ABORT_EN
  assign abort = abort_i & (state_q == ST_RUN);
`else
  assign abort = 1'b0;
`endif

  assign load = (state_q == ST_IDLE) & start_i;
  assign xfer = (state_q == ST_RUN) & out_ready_i & ~abort;

  // New row base of the lowest non-wrapping dim, copied down into all wrapping dims.
  always_comb begin
    logic found;
    found = 1'b0;
    bcast = rb_all[0] + stride_all[0];
    for (int d = 0; d < NUM_DIMS; d++) begin
      if (!found && !last_vec[d]) begin
        bcast = rb_all[d] + stride_all[d];
        found = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIMS; gi++) begin : g_dim
      logic                  c_in, c_out, last_w;
      logic [CNT_WIDTH-1:0]  bound_q, idx_w;
      logic [ADDR_WIDTH-1:0] stride_q, rb_w;

      if (gi == 0) begin : g_first
        assign c_in = xfer;
      end else begin : g_chain
        assign c_in = g_dim[gi-1].c_out;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bound_q  <= '0;
          stride_q <= '0;
        end else if (load) begin
          bound_q  <= CNT_WIDTH'(sanitise_bound(32'(bound_i[gi*CNT_WIDTH +: CNT_WIDTH])));
          stride_q <= stride_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end

      conv_loop_dim_stage #(
        .CNT_WIDTH (CNT_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .base_i  (base_i),
        .bound_i (bound_q),
        .stride_i(stride_q),
        .carry_i (c_in),
        .bcast_i (bcast),
        .idx_o   (idx_w),
        .last_o  (last_w),
        .carry_o (c_out),
        .rb_o    (rb_w)
      );

      assign last_vec[gi]                        = last_w;
      assign rb_all[gi]                          = rb_w;
      assign stride_all[gi]                      = stride_q;
      assign idx_o[gi*CNT_WIDTH +: CNT_WIDTH]    = idx_w;
    end
  endgenerate

  assign final_xfer = g_dim[NUM_DIMS-1].c_out;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)           state_d = ST_IDLE;
        else if (final_xfer) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign valid_o = (state_q == ST_RUN);
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign addr_o  = rb_all[0];
  assign last_o  = last_vec & {NUM_DIMS{valid_o}};

endmodule

// File: tb/tb_conv_loop_addr_counter.sv
// Randomised bench for conv_loop_addr_counter against a mixed-radix address model.
module tb_conv_loop_addr_counter;

  localparam int ND = 3;
  localparam int CW = 8;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [AW-1:0]     base_i = '0;
  logic [ND*CW-1:0]  bound_i = '0;
  logic [ND*AW-1:0]  stride_i = '0;
  logic              out_ready_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              valid_o, busy_o, done_o;
  logic [AW-1:0]     addr_o;
  logic [ND*CW-1:0]  idx_o;
  logic [ND-1:0]     last_o;

  conv_loop_addr_counter #(.NUM_DIMS(ND), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .base_i     (base_i),
    .bound_i    (bound_i),
    .stride_i   (stride_i),
    .out_ready_i(out_ready_i),
`ifdef CONV_CNT_ABORT_EN
    .abort_i    (abort_i),
`endif
    .valid_o    (valid_o),
    .addr_o     (addr_o),
    .idx_o      (idx_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [ND*CW-1:0] idx;
    logic [ND-1:0]    last;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   pops = 0;
  bit   m_active = 0;
  bit   done_pending = 0;
  bit   chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer n has indices given by n written in mixed radix of the bounds;
  // its address is base plus the stride-weighted index sum.
  task automatic build(input logic [AW-1:0] base, input logic [ND*CW-1:0] bnd,
                       input logic [ND*AW-1:0] str);
    int b[ND];
    int n_tot;
    n_tot = 1;
    q.delete();
    for (int d = 0; d < ND; d++) begin
      b[d] = int'(bnd[d*CW +: CW]);
      if (b[d] == 0) b[d] = 1;
      n_tot = n_tot * b[d];
    end
    for (int n = 0; n < n_tot; n++) begin
      exp_t e;
      int   rem;
      rem    = n;
      e.addr = base;
      e.idx  = '0;
      e.last = '0;
      for (int d = 0; d < ND; d++) begin
        int i;
        i = rem % b[d];
        rem = rem / b[d];
        e.addr = e.addr + AW'(i * int'(str[d*AW +: AW]));
        e.idx[d*CW +: CW] = CW'(i);
        e.last[d] = (i == b[d] - 1);
      end
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_valid;
      exp_valid = m_active && (q.size() > 0);
      chk("valid", {63'd0, valid_o}, {63'd0, exp_valid});
      chk("busy", {63'd0, busy_o}, {63'd0, exp_valid | done_pending});
      chk("done", {63'd0, done_o}, {63'd0, done_pending});
      if (exp_valid) begin
        chk("addr", 64'(addr_o), 64'(q[0].addr));
        chk("idx", 64'(idx_o), 64'(q[0].idx));
        chk("last", 64'(last_o), 64'(q[0].last));
      end else begin
        chk("last_idle", 64'(last_o), 64'd0);
      end
      done_pending = 0;
      if (exp_valid && abort_i) begin
        q.delete();
        m_active = 0;
      end else if (exp_valid && out_ready_i) begin
        void'(q.pop_front());
        pops++;
        if (q.size() == 0) begin
          m_active     = 0;
          done_pending = 1;
        end
      end
    end
  end

  // mode 0: ready high, 1: ready 1-0-0-1 pattern, 2: random ready.
  task automatic run_cfg(input logic [AW-1:0] base, input logic [ND*CW-1:0] bnd,
                         input logic [ND*AW-1:0] str, input int mode, input bit poke,
                         input int abort_at);
    int cyc;
    int n_exp;
    build(base, bnd, str);
    n_exp = q.size();
    pops = 0;
    @(posedge clk); #1;
    base_i = base; bound_i = bnd; stride_i = str; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    m_active = 1;
    base_i = AW'($urandom); bound_i = ND*CW'($urandom); stride_i = ND*AW'($urandom);
    cyc = 0;
    while (m_active && cyc < 5000) begin
      case (mode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready_i = ($urandom_range(3, 0) != 0);
      endcase
      start_i = poke && (cyc == 3);
      abort_i = (abort_at >= 0) && (pops == abort_at);
      if (abort_i) out_ready_i = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("run_timeout", {63'd0, m_active}, 64'd0);
    m_active = 0;
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("run base=%h bounds=%h mode=%0d transfers=%0d expected=%0d", base, bnd, mode,
             pops, (abort_at >= 0) ? abort_at : n_exp);
  endtask

  initial begin
    #12;
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_idx", 64'(idx_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1;

    build(16'h0100, {8'd2, 8'd3, 8'd4}, {16'h0040, 16'h0010, 16'h0001});
    chk("t1_len", 64'(q.size()), 64'd24);
    chk("t1_a1", 64'(q[1].addr), 64'h101);
    chk("t1_a4", 64'(q[4].addr), 64'h110);
    chk("t1_a12", 64'(q[12].addr), 64'h140);
    chk("t1_a23", 64'(q[23].addr), 64'h163);
    chk("t1_l23", 64'(q[23].last), 64'h7);
    run_cfg(16'h0100, {8'd2, 8'd3, 8'd4}, {16'h0040, 16'h0010, 16'h0001}, 0, 0, -1);
    chk("t1_pops", 64'(pops), 64'd24);
    run_cfg(16'h0100, {8'd2, 8'd3, 8'd4}, {16'h0040, 16'h0010, 16'h0001}, 1, 0, -1);
    chk("t2_pops", 64'(pops), 64'd24);

    build(16'h0AB0, {8'd1, 8'd1, 8'd0}, {16'h0005, 16'h0006, 16'h0007});
    chk("t3_len", 64'(q.size()), 64'd1);
    chk("t3_last", 64'(q[0].last), 64'h7);
    run_cfg(16'h0AB0, {8'd1, 8'd1, 8'd0}, {16'h0005, 16'h0006, 16'h0007}, 0, 0, -1);

    build(16'hFFF0, {8'd1, 8'd1, 8'd40}, {16'h0, 16'h0, 16'h0001});
    chk("t4_a15", 64'(q[15].addr), 64'hFFFF);
    chk("t4_a16", 64'(q[16].addr), 64'h0000);
    run_cfg(16'hFFF0, {8'd1, 8'd1, 8'd40}, {16'h0, 16'h0, 16'h0001}, 0, 0, -1);

    run_cfg(16'h2000, {8'd3, 8'd2, 8'd5}, {16'h0100, 16'h0020, 16'h0002}, 2, 1, -1);

    // Reset asserted in the middle of a run.
    build(16'h0300, {8'd4, 8'd4, 8'd4}, {16'h0100, 16'h0010, 16'h0001});
    @(posedge clk); #1;
    base_i = 16'h0300; bound_i = {8'd4, 8'd4, 8'd4};
    stride_i = {16'h0100, 16'h0010, 16'h0001}; start_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; m_active = 1;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    q.delete(); m_active = 0; done_pending = 0;
    #1;
    chk("mrst_valid", {63'd0, valid_o}, 64'd0);
    chk("mrst_busy", {63'd0, busy_o}, 64'd0);
    chk("mrst_addr", 64'(addr_o), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset mid-run issued");

`ifdef CONV_CNT_ABORT_EN
    run_cfg(16'h0100, {8'd2, 8'd3, 8'd4}, {16'h0040, 16'h0010, 16'h0001}, 0, 0, 4);
    chk("abort_pops", 64'(pops), 64'd4);
    run_cfg(16'h0500, {8'd1, 8'd2, 8'd3}, {16'h0, 16'h0100, 16'h0004}, 0, 0, -1);
    chk("post_abort_pops", 64'(pops), 64'd6);
`endif

    for (int r = 0; r < 10; r++) begin
      logic [ND*CW-1:0] bnd;
      logic [ND*AW-1:0] str;
      for (int d = 0; d < ND; d++) begin
        bnd[d*CW +: CW] = CW'($urandom_range(5, 0));
        str[d*AW +: AW] = AW'($urandom);
      end
      run_cfg(AW'($urandom), bnd, str, 2, (r % 3 == 0), -1);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
